// File: rtl/periph_bridge.sv
// periph_bridge: takes one uncached access from the core data port, decodes it into one
// of SLOTS 256-byte device windows and runs a select/ready handshake with timeout.
package periph_bridge_pkg;
  typedef enum logic [2:0] {
    NO_STORE    = 3'd0,
    STORE_BYTE  = 3'd1,
    STORE_HALF  = 3'd2,
    STORE_WORD  = 3'd3,
    STORE_DWORD = 3'd4
  } mem_store_type_t;
endpackage

module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
  parameter int          SLOTS           = 8,
  parameter int          TIMEOUT         = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [63:0]           d_addr,
  input  logic [63:0]           d_wdata,
  input  mem_store_type_t       d_store_type,
  input  logic                  d_valid,
  output logic [63:0]           d_rdata,
  output logic                  d_ready,
  output logic [SLOTS-1:0]      p_sel,
  output logic                  p_write,
  output logic [7:0]            p_addr,
  output logic [63:0]           p_wdata,
  output logic [7:0]            p_be,
  input  logic [SLOTS-1:0][63:0] p_rdata,
  input  logic [SLOTS-1:0]      p_ready,
  output logic                  bus_error,
  output logic [63:0]           err_addr
);

  localparam logic [63:0] WIN_SPAN  = 64'(SLOTS) * 64'd256;
  localparam logic [9:0]  TMO_CNT   = 10'(TIMEOUT);
  localparam logic [63:0] ERR_DATA  = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Byte-lane mask of an access before shifting into place; reads move a full dword.
  function automatic logic [7:0] lane_mask(input mem_store_type_t st);
    case (st)
      STORE_BYTE: lane_mask = 8'h01;
      STORE_HALF: lane_mask = 8'h03;
      STORE_WORD: lane_mask = 8'h0F;
      default:    lane_mask = 8'hFF;
    endcase
  endfunction

  // Undefined store encodings are rejected like a misaligned access.
  function automatic logic is_aligned(input mem_store_type_t st, input logic [2:0] lo);
    case (st)
      NO_STORE, STORE_DWORD: is_aligned = (lo == 3'd0);
      STORE_WORD:            is_aligned = (lo[1:0] == 2'd0);
      STORE_HALF:            is_aligned = (lo[0] == 1'b0);
      STORE_BYTE:            is_aligned = 1'b1;
      default:               is_aligned = 1'b0;
    endcase
  endfunction

  state_t                  state_r;
  logic [9:0]              cnt_r;
  logic                    guard_r;
  logic [63:0]             addr_r;
  logic [2:0]              lo_r;
  logic [SLOTS-1:0]        p_sel_r;
  logic                    p_write_r;
  logic [7:0]              p_addr_r;
  logic [63:0]             p_wdata_r;
  logic [7:0]              p_be_r;
  logic [63:0]             d_rdata_r;
  logic                    d_ready_r;
  logic                    bus_error_r;
  logic [63:0]             err_addr_r;

  logic [63:0]             off_s;
  logic                    mapped_s;
  logic                    aligned_s;
  logic                    ready_s;
  logic [SLOTS-1:0]        sel_onehot_s;
  logic [SLOTS:0][63:0]    rchain_s;

  // Selected-slot read data is an OR of masked slot buses; p_sel_r is one-hot in REQ.
  assign rchain_s[0] = 64'd0;
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    assign sel_onehot_s[g] = (off_s[11:8] == 4'(g));
    assign rchain_s[g+1]   = rchain_s[g] | (p_sel_r[g] ? p_rdata[g] : 64'd0);
  end

  // Address decode of the incoming request.
  always_comb begin
    off_s     = d_addr - PERIPHERAL_BASE;
    mapped_s  = (d_addr >= PERIPHERAL_BASE) && (off_s < WIN_SPAN);
    aligned_s = is_aligned(d_store_type, off_s[2:0]);
    ready_s   = |(p_ready & p_sel_r);
  end

  // Access FSM with all bus and core-side outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= 10'd0;
      guard_r     <= 1'b0;
      addr_r      <= 64'd0;
      lo_r        <= 3'd0;
      p_sel_r     <= '0;
      p_write_r   <= 1'b0;
      p_addr_r    <= 8'd0;
      p_wdata_r   <= 64'd0;
      p_be_r      <= 8'd0;
      d_rdata_r   <= 64'd0;
      d_ready_r   <= 1'b0;
      bus_error_r <= 1'b0;
      err_addr_r  <= 64'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          d_ready_r   <= 1'b0;
          bus_error_r <= 1'b0;
          d_rdata_r   <= 64'd0;
          if (guard_r) begin
            // The core still presents its finished request in this cycle.
            guard_r <= 1'b0;
          end else if (d_valid) begin
            addr_r <= d_addr;
            lo_r   <= off_s[2:0];
            if (mapped_s && aligned_s) begin
              state_r   <= S_REQ;
              cnt_r     <= 10'd0;
              p_sel_r   <= sel_onehot_s;
              p_write_r <= (d_store_type != NO_STORE);
              p_addr_r  <= off_s[7:0];
              p_wdata_r <= d_wdata << {off_s[2:0], 3'b000};
              p_be_r    <= lane_mask(d_store_type) << off_s[2:0];
            end else begin
              state_r     <= S_RESP;
              d_ready_r   <= 1'b1;
              bus_error_r <= 1'b1;
              d_rdata_r   <= ERR_DATA;
              err_addr_r  <= d_addr;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_REQ: begin
          if (ready_s || (cnt_r == TMO_CNT)) begin
            state_r   <= S_RESP;
            d_ready_r <= 1'b1;
            p_sel_r   <= '0;
            p_write_r <= 1'b0;
            p_addr_r  <= 8'd0;
            p_wdata_r <= 64'd0;
            p_be_r    <= 8'd0;
            if (ready_s) begin
              d_rdata_r <= p_write_r ? 64'd0 : (rchain_s[SLOTS] >> {lo_r, 3'b000});
            end else begin
              bus_error_r <= 1'b1;
              d_rdata_r   <= ERR_DATA;
              err_addr_r  <= addr_r;
            end
          end else begin
            cnt_r <= cnt_r + 10'd1;
          end
        end
        S_RESP: begin
          state_r     <= S_IDLE;
          guard_r     <= 1'b1;
          d_ready_r   <= 1'b0;
          bus_error_r <= 1'b0;
          d_rdata_r   <= 64'd0;
        end
        default: begin
          state_r     <= S_IDLE;
          guard_r     <= 1'b0;
          p_sel_r     <= '0;
          p_write_r   <= 1'b0;
          p_addr_r    <= 8'd0;
          p_wdata_r   <= 64'd0;
          p_be_r      <= 8'd0;
          d_ready_r   <= 1'b0;
          bus_error_r <= 1'b0;
          d_rdata_r   <= 64'd0;
        end
      endcase
    end
  end

  assign d_rdata   = d_rdata_r;
  assign d_ready   = d_ready_r;
  assign p_sel     = p_sel_r;
  assign p_write   = p_write_r;
  assign p_addr    = p_addr_r;
  assign p_wdata   = p_wdata_r;
  assign p_be      = p_be_r;
  assign bus_error = bus_error_r;
  assign err_addr  = err_addr_r;

endmodule
